// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - SimpleRISC opcodes, instruction field positions and immediate modifiers
package simplerisc_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_MUL  = 5'b00010,
    OP_DIV  = 5'b00011,
    OP_MOD  = 5'b00100,
    OP_CMP  = 5'b00101,
    OP_AND  = 5'b00110,
    OP_OR   = 5'b00111,
    OP_NOT  = 5'b01000,
    OP_MOV  = 5'b01001,
    OP_LSL  = 5'b01010,
    OP_LSR  = 5'b01011,
    OP_ASR  = 5'b01100,
    OP_NOP  = 5'b01101,
    OP_LD   = 5'b01110,
    OP_ST   = 5'b01111,
    OP_BEQ  = 5'b10000,
    OP_BGT  = 5'b10001,
    OP_B    = 5'b10010,
    OP_CALL = 5'b10011,
    OP_RET  = 5'b10100
  } opcode_e;

  typedef enum logic [1:0] {
    MOD_SEXT  = 2'b00,
    MOD_ZEXT  = 2'b01,
    MOD_HIGH  = 2'b10,
    MOD_SEXT2 = 2'b11
  } imm_mod_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int I_BIT   = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 22;
  localparam int RS1_MSB = 21;
  localparam int RS1_LSB = 18;
  localparam int RS2_MSB = 17;
  localparam int RS2_LSB = 14;
  localparam int MOD_MSB = 17;
  localparam int MOD_LSB = 16;
  localparam int IMM_MSB = 15;

  localparam int RA_IDX_DEFAULT = 15;

  // Branch-class opcodes carry a 27-bit offset instead of an imm16
  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_B) || (op == OP_BEQ) || (op == OP_BGT) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/operand_imm_gen.sv
// rtl/operand_imm_gen.sv - combinational immediate extender (instr -> imm32)
module operand_imm_gen
  import simplerisc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [4:0]  w_opcode;
  logic [1:0]  w_mod;
  logic [15:0] w_imm16;

  assign w_opcode = i_instr[OPC_MSB:OPC_LSB];
  assign w_mod    = i_instr[MOD_MSB:MOD_LSB];
  assign w_imm16  = i_instr[IMM_MSB:0];

  // Select the extension: branch offsets first, otherwise by modifier
  always_comb begin
    o_imm = {{(XLEN-16){w_imm16[15]}}, w_imm16};
    if (is_branch(w_opcode)) begin
      o_imm = {{(XLEN-27){i_instr[I_BIT]}}, i_instr[I_BIT:0]};
    end else begin
      case (w_mod)
        MOD_ZEXT: o_imm = {{(XLEN-16){1'b0}}, w_imm16};
        MOD_HIGH: o_imm = XLEN'({w_imm16, 16'h0000});
        default:  o_imm = {{(XLEN-16){w_imm16[15]}}, w_imm16};
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - SimpleRISC operand fetch: RF read, forwarding, load-use stall, OF/EX latch
module operand_fetch_stage
  import simplerisc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RA_IDX = RA_IDX_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [3:0]      rf_addr1,
  output logic [3:0]      rf_addr2,
  input  logic [XLEN-1:0] rf_data1,
  input  logic [XLEN-1:0] rf_data2,
  input  logic            ex_fwd_valid,
  input  logic [3:0]      ex_fwd_rd,
  input  logic [XLEN-1:0] ex_fwd_data,
  input  logic            ex_fwd_is_ld,
  input  logic            wb_fwd_valid,
  input  logic [3:0]      wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            of_valid,
  output logic [XLEN-1:0] of_pc,
  output logic [XLEN-1:0] of_instr,
  output logic [XLEN-1:0] of_op1,
  output logic [XLEN-1:0] of_op2,
  output logic [XLEN-1:0] of_imm,
  output logic [3:0]      of_rd
);

  logic [4:0]      w_opcode;
  logic [3:0]      w_rd;
  logic [3:0]      w_rs1;
  logic [3:0]      w_rs2;
  logic            w_ex_hit1;
  logic            w_ex_hit2;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic [XLEN-1:0] w_op1;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_imm;
  logic            w_stall;
  logic            w_accept;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic [XLEN-1:0] r_imm;
  logic [3:0]      r_rd;

  assign w_opcode = if_instr[OPC_MSB:OPC_LSB];
  assign w_rd     = if_instr[RD_MSB:RD_LSB];
  assign w_rs1    = if_instr[RS1_MSB:RS1_LSB];
  assign w_rs2    = if_instr[RS2_MSB:RS2_LSB];

  // ret reads the return-address register; st reads its data register through port 2
  assign rf_addr1 = (w_opcode == OP_RET) ? 4'(RA_IDX) : w_rs1;
  assign rf_addr2 = (w_opcode == OP_ST)  ? w_rd       : w_rs2;

  // A load in EX has no data yet, so it never forwards; it stalls instead
  assign w_ex_hit1 = ex_fwd_valid && !ex_fwd_is_ld && (ex_fwd_rd == rf_addr1);
  assign w_ex_hit2 = ex_fwd_valid && !ex_fwd_is_ld && (ex_fwd_rd == rf_addr2);
  assign w_wb_hit1 = wb_fwd_valid && (wb_fwd_rd == rf_addr1);
  assign w_wb_hit2 = wb_fwd_valid && (wb_fwd_rd == rf_addr2);

  assign w_op1 = w_ex_hit1 ? ex_fwd_data : (w_wb_hit1 ? wb_fwd_data : rf_data1);
  assign w_op2 = w_ex_hit2 ? ex_fwd_data : (w_wb_hit2 ? wb_fwd_data : rf_data2);

  // Conservative: both read ports are compared even if the opcode uses only one
  assign w_stall  = if_valid && ex_fwd_valid && ex_fwd_is_ld &&
                    ((ex_fwd_rd == rf_addr1) || (ex_fwd_rd == rf_addr2));
  assign if_ready = (!r_valid || ex_ready) && !w_stall && !flush;
  assign w_accept = if_valid && if_ready;

  operand_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  // OF/EX latch: flush squashes, accept loads, a drained slot becomes a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_imm   <= '0;
      r_rd    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= if_pc;
      r_instr <= if_instr;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_imm   <= w_imm;
      r_rd    <= w_rd;
    end else if (ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign of_valid = r_valid;
  assign of_pc    = r_pc;
  assign of_instr = r_instr;
  assign of_op1   = r_op1;
  assign of_op2   = r_op2;
  assign of_imm   = r_imm;
  assign of_rd    = r_rd;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;

  logic        clk;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [3:0]  rf_addr1;
  logic [3:0]  rf_addr2;
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic        ex_fwd_valid;
  logic [3:0]  ex_fwd_rd;
  logic [31:0] ex_fwd_data;
  logic        ex_fwd_is_ld;
  logic        wb_fwd_valid;
  logic [3:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic        ex_ready;
  logic        of_valid;
  logic [31:0] of_pc;
  logic [31:0] of_instr;
  logic [31:0] of_op1;
  logic [31:0] of_op2;
  logic [31:0] of_imm;
  logic [3:0]  of_rd;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference latch contents
  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_op1, m_op2, m_imm;
  logic [3:0]  m_rd;

  operand_fetch_stage dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .ex_fwd_is_ld(ex_fwd_is_ld),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .ex_ready(ex_ready),
    .of_valid(of_valid), .of_pc(of_pc), .of_instr(of_instr), .of_op1(of_op1),
    .of_op2(of_op2), .of_imm(of_imm), .of_rd(of_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [31:0] op, input logic [31:0] rd,
                                     input logic [31:0] rs1, input logic [31:0] rs2);
    return (op << 27) | (rd << 22) | (rs1 << 18) | (rs2 << 14);
  endfunction

  function automatic logic [31:0] mk_imm(input logic [31:0] op, input logic [31:0] rd,
                                         input logic [31:0] rs1, input logic [31:0] md,
                                         input logic [31:0] imm16);
    return (op << 27) | (32'd1 << 26) | (rd << 22) | (rs1 << 18) | (md << 16) | imm16;
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] op, md, v;
    op = ins >> 27;
    md = (ins >> 16) % 4;
    v  = ins % 32'h10000;
    if (op >= 16 && op <= 19) begin
      v = ins % 32'h0800_0000;
      return (v >= 32'h0400_0000) ? v - 32'h0800_0000 : v;
    end
    if (md == 1) return v;
    if (md == 2) return v * 32'h10000;
    return (v >= 32'h8000) ? v - 32'h10000 : v;
  endfunction

  function automatic logic [31:0] ref_val(input logic [3:0] a, input logic [31:0] rf);
    if (ex_fwd_valid && !ex_fwd_is_ld && ex_fwd_rd == a) return ex_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == a) return wb_fwd_data;
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_pc = 0; m_instr = 0; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".of_valid"}, 32'(of_valid), 32'(m_valid));
    chk({tag, ".of_pc"},    of_pc,    m_pc);
    chk({tag, ".of_instr"}, of_instr, m_instr);
    chk({tag, ".of_op1"},   of_op1,   m_op1);
    chk({tag, ".of_op2"},   of_op2,   m_op2);
    chk({tag, ".of_imm"},   of_imm,   m_imm);
    chk({tag, ".of_rd"},    32'(of_rd), 32'(m_rd));
  endtask

  // One clock: inputs already driven at the falling edge; check, clock, check
  task automatic cycle(input string tag);
    logic [31:0] op;
    logic [3:0]  a1, a2;
    logic        stall, rdy;
    logic [31:0] o1, o2;
    #1;
    op = if_instr >> 27;
    a1 = (op == 20) ? 4'd15 : 4'((if_instr >> 18) % 16);
    a2 = (op == 15) ? 4'((if_instr >> 22) % 16) : 4'((if_instr >> 14) % 16);
    stall = if_valid && ex_fwd_valid && ex_fwd_is_ld && (ex_fwd_rd == a1 || ex_fwd_rd == a2);
    rdy = (!m_valid || ex_ready) && !stall && !flush;
    chk({tag, ".rf_addr1"}, 32'(rf_addr1), 32'(a1));
    chk({tag, ".rf_addr2"}, 32'(rf_addr2), 32'(a2));
    chk({tag, ".if_ready"}, 32'(if_ready), 32'(rdy));
    o1 = ref_val(a1, rf_data1);
    o2 = ref_val(a2, rf_data2);
    @(posedge clk);
    #1;
    if (flush) m_valid = 0;
    else if (if_valid && rdy) begin
      m_valid = 1; m_pc = if_pc; m_instr = if_instr; m_op1 = o1; m_op2 = o2;
      m_imm = ref_imm(if_instr); m_rd = 4'((if_instr >> 22) % 16);
    end else if (ex_ready) m_valid = 0;
    chk_outputs(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_instr = 0; if_pc = 0; rf_data1 = 0; rf_data2 = 0;
    ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_is_ld = 0;
    wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0; flush = 0; ex_ready = 1;
  endtask

  logic [31:0] saved;

  initial begin
    idle_inputs();
    reset = 1;
    model_clear();
    @(negedge clk);
    chk_outputs("reset0");
    reset = 0;
    #1 chk("reset0.if_ready", 32'(if_ready), 32'd1);

    // add r3,r1,r2
    if_valid = 1; if_pc = 32'h100; if_instr = mk(0, 3, 1, 2);
    rf_data1 = 5; rf_data2 = 7;
    cycle("add");
    chk("add.valid", 32'(of_valid), 1); chk("add.op1", of_op1, 5);
    chk("add.op2", of_op2, 7);          chk("add.rd", 32'(of_rd), 3);

    // st r4,[r1] and ret
    if_pc = 32'h104; if_instr = mk(15, 4, 1, 0);
    #1 chk("st.rf_addr2", 32'(rf_addr2), 4);
    cycle("st");
    if_pc = 32'h108; if_instr = mk(20, 0, 0, 0);
    #1 chk("ret.rf_addr1", 32'(rf_addr1), 15);
    cycle("ret");

    // EX beats WB on the same register, then WB alone
    if_instr = mk(0, 1, 2, 3);
    ex_fwd_valid = 1; ex_fwd_rd = 2; ex_fwd_data = 32'hAA;
    wb_fwd_valid = 1; wb_fwd_rd = 2; wb_fwd_data = 32'hBB;
    cycle("fwd_ex");
    chk("fwd_ex.op1", of_op1, 32'hAA);
    ex_fwd_valid = 0;
    cycle("fwd_wb");
    chk("fwd_wb.op1", of_op1, 32'hBB);

    // Load-use on rs2
    wb_fwd_valid = 0;
    ex_fwd_valid = 1; ex_fwd_is_ld = 1; ex_fwd_rd = 6;
    if_pc = 32'h200; if_instr = mk(1, 1, 5, 6);
    #1 chk("ldu.if_ready", 32'(if_ready), 0);
    cycle("ldu_stall");
    chk("ldu.bubble", 32'(of_valid), 0);
    ex_fwd_is_ld = 0; ex_fwd_valid = 0;
    wb_fwd_valid = 1; wb_fwd_rd = 6; wb_fwd_data = 32'h1234;
    cycle("ldu_go");
    chk("ldu.op2", of_op2, 32'h1234);
    wb_fwd_valid = 0;

    // Backpressure for 3 cycles, then release
    saved = of_instr;
    ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'h300 + 32'(i); if_instr = mk(2, 7, 8, 9) + 32'(i);
      #1 chk("bp.if_ready", 32'(if_ready), 0);
      cycle("bp_hold");
      chk("bp.instr_held", of_instr, saved);
    end
    ex_ready = 1;
    if_instr = mk(3, 9, 10, 11);
    #1 chk("bp.release_ready", 32'(if_ready), 1);
    cycle("bp_release");
    chk("bp.loaded", of_instr, mk(3, 9, 10, 11));

    // Immediate modifiers
    if_instr = mk_imm(0, 1, 1, 0, 32'h8001); cycle("imm00");
    chk("imm.mod00", of_imm, 32'hFFFF8001);
    if_instr = mk_imm(0, 1, 1, 1, 32'h8001); cycle("imm01");
    chk("imm.mod01", of_imm, 32'h00008001);
    if_instr = mk_imm(0, 1, 1, 2, 32'h8001); cycle("imm10");
    chk("imm.mod10", of_imm, 32'h80010000);
    if_instr = 32'h9400_0005; cycle("imm_br");

    // Flush concurrent with a valid instruction
    flush = 1; if_instr = mk(0, 2, 3, 4);
    #1 chk("flush.if_ready", 32'(if_ready), 0);
    cycle("flush");
    chk("flush.valid", 32'(of_valid), 0);
    flush = 0;

    // Asynchronous reset while holding
    cycle("pre_rst");
    ex_ready = 0;
    cycle("hold_rst");
    #2 reset = 1;
    #1 model_clear();
    chk_outputs("async_rst");
    @(negedge clk);
    reset = 0; ex_ready = 1; if_valid = 0;
    #1 chk("after_rst.if_ready", 32'(if_ready), 1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if_valid     = ($urandom_range(0, 3) != 0);
      if_instr     = ($urandom_range(0, 20) << 27) | ($urandom % 32'h0800_0000);
      if_pc        = $urandom;
      rf_data1     = $urandom;
      rf_data2     = $urandom;
      ex_fwd_valid = $urandom_range(0, 1);
      ex_fwd_rd    = 4'($urandom_range(0, 15));
      ex_fwd_data  = $urandom;
      ex_fwd_is_ld = ($urandom_range(0, 3) == 0);
      wb_fwd_valid = $urandom_range(0, 1);
      wb_fwd_rd    = 4'($urandom_range(0, 15));
      wb_fwd_data  = $urandom;
      flush        = ($urandom_range(0, 7) == 0);
      ex_ready     = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
